// File: rtl/seg14_pkg.sv
// Character codes, widths and the 14-segment font shared by the scroll display and its font lookup.
// Segment bit order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

   localparam int CHAR_W = 6;
   localparam int SEG_W  = 14;

   localparam logic [CHAR_W-1:0] CODE_A     = 6'd0;
   localparam logic [CHAR_W-1:0] CODE_Z     = 6'd25;
   localparam logic [CHAR_W-1:0] CODE_0     = 6'd26;
   localparam logic [CHAR_W-1:0] CODE_9     = 6'd35;
   localparam logic [CHAR_W-1:0] CODE_SPACE = 6'd36;

   localparam logic [SEG_W-1:0] FONT_A     = 14'b11101111000000;
   localparam logic [SEG_W-1:0] FONT_E     = 14'b10011110000000;
   localparam logic [SEG_W-1:0] FONT_S     = 14'b10110111000000;
   localparam logic [SEG_W-1:0] FONT_T     = 14'b10000000010010;
   localparam logic [SEG_W-1:0] FONT_SPACE = 14'b00000000000000;

   // Indexed directly by character code; codes above CODE_SPACE are blank.
   localparam logic [SEG_W-1:0] FONT_ROM [37] = '{
      FONT_A,            14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
      FONT_E,            14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
      14'b10010000010010, 14'b01111000000000, 14'b00001110001001, 14'b00011100000000,
      14'b01101100101000, 14'b01101100100001, 14'b11111100000000, 14'b11001111000000,
      14'b11111100000001, 14'b11001111000001, FONT_S,            FONT_T,
      14'b01111100000000, 14'b00001100001100, 14'b01101100000101, 14'b00000000101101,
      14'b00000000101010, 14'b10010000001100,
      14'b11111100001100, 14'b01100000001000, 14'b11011011000000, 14'b11110001000000,
      14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
      14'b11111111000000, 14'b11110111000000,
      FONT_SPACE
   };

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment pattern lookup; zero latency, no flow control.
module seg14_font
   import seg14_pkg::*;
(
   input  logic [CHAR_W-1:0] code,
   output logic [SEG_W-1:0]  pattern
);

   always_comb begin
      pattern = FONT_SPACE;
      if (code <= CODE_SPACE) begin
         pattern = FONT_ROM[code];
      end
   end

endmodule

// File: rtl/seg14_scroll_display.sv
// Multiplexed 14-segment scanner with double-buffered message and scroll; outputs registered, 1-cycle latency.
// wr_ready is low while a commit waits for the frame boundary; SEG14_DIM_EN adds PWM brightness control.
module seg14_scroll_display
   import seg14_pkg::*;
#(
   parameter int  N_DIGITS    = 12,
   parameter int  MSG_LEN     = 16,
   parameter int  REFRESH_DIV = 1,
   parameter int  SCROLL_DIV  = 64,
   localparam int AW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
`ifdef USE_POWER_PINS
   inout  wire                vdd,
   inout  wire                vss,
`endif
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [CHAR_W-1:0]  wr_char,
   output logic               wr_ready,
   input  logic               msg_commit,
   input  logic               scroll_en,
`ifdef SEG14_DIM_EN
   input  logic [3:0]         brightness,
`endif
   output logic [N_DIGITS-1:0] sel,
   output logic [SEG_W-1:0]   segm,
   output logic               frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_DIV - 1);
   localparam logic [AW-1:0] OFF_LAST  = AW'(MSG_LEN - 1);
   localparam logic [AW:0]   MSG_LEN_W = (AW+1)'(MSG_LEN);

   logic [PW-1:0]     prescaler;
   logic [DW-1:0]     digit;
   logic [AW-1:0]     offset;
   logic [FW-1:0]     frame_cnt;
   logic              commit_pending;
   logic [CHAR_W-1:0] shadow [MSG_LEN];
   logic [CHAR_W-1:0] active [MSG_LEN];

   logic              slot_end;
   logic              frame_end;
   logic [AW:0]       idx_sum;
   logic [AW-1:0]     slot_idx;
   logic [SEG_W-1:0]  glyph;
   logic              dim_off;

   always_comb begin
      slot_end  = (prescaler == PRE_LAST);
      frame_end = slot_end && (digit == DIG_LAST);
      idx_sum   = {1'b0, offset} + (AW+1)'(digit);
      slot_idx  = (idx_sum >= MSG_LEN_W) ? AW'(idx_sum - MSG_LEN_W) : idx_sum[AW-1:0];
   end

   seg14_font u_font (
      .code    (active[slot_idx]),
      .pattern (glyph)
   );

`ifdef SEG14_DIM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= 4'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   assign dim_off = (pwm_cnt > brightness);
`else
   assign dim_off = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler      <= '0;
         digit          <= '0;
         offset         <= '0;
         frame_cnt      <= '0;
         commit_pending <= 1'b0;
         wr_ready       <= 1'b1;
         sel            <= '0;
         segm           <= '0;
         frame_tick     <= 1'b0;
         for (int i = 0; i < MSG_LEN; i++) begin
            shadow[i] <= CODE_SPACE;
            active[i] <= CODE_SPACE;
         end
      end else begin
         sel        <= N_DIGITS'(1) << digit;
         segm       <= dim_off ? '0 : glyph;
         frame_tick <= frame_end;
         prescaler  <= slot_end ? '0 : prescaler + PW'(1);
         if (slot_end) begin
            digit <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
         end

         if (wr_en && wr_ready && ((AW+1)'(wr_addr) < MSG_LEN_W)) begin
            shadow[wr_addr] <= wr_char;
         end
         if (msg_commit && wr_ready) begin
            commit_pending <= 1'b1;
            wr_ready       <= 1'b0;
         end

         if (frame_end && scroll_en) begin
            if (frame_cnt == FRM_LAST) begin
               frame_cnt <= '0;
               offset    <= (offset == OFF_LAST) ? '0 : offset + AW'(1);
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end

         // The copy lands on the frame wrap edge, so the next frame is drawn entirely from the new text.
         if (frame_end && commit_pending) begin
            for (int i = 0; i < MSG_LEN; i++) begin
               active[i] <= shadow[i];
            end
            offset         <= '0;
            frame_cnt      <= '0;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg14_scroll_display.sv
// Directed bench: scan order, refresh division, commit handshake, scrolling and reset mid-commit.
module tb_seg14_scroll_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, wr_en, msg_commit, scroll_en;
   logic [3:0]  wr_addr;
   logic [5:0]  wr_char;
   logic        wr_ready, frame_tick, wr_ready4, frame_tick4;
   logic [11:0] sel, sel4;
   logic [13:0] segm, segm4;
`ifdef SEG14_DIM_EN
   logic [3:0]  brightness = 4'd15;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [11:0] sel;
      logic [13:0] segm;
      logic        tick;
      logic        rdy;
      logic [11:0] sel4;
      logic        tick4;
   } exp_t;

   exp_t sb[$];
   byte  shadow_m [16];
   byte  active_m [16];

   seg14_scroll_display #(.N_DIGITS(12), .MSG_LEN(16), .REFRESH_DIV(1), .SCROLL_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
      .wr_ready(wr_ready), .msg_commit(msg_commit), .scroll_en(scroll_en),
`ifdef SEG14_DIM_EN
      .brightness(brightness),
`endif
      .sel(sel), .segm(segm), .frame_tick(frame_tick)
   );

   seg14_scroll_display #(.N_DIGITS(12), .MSG_LEN(16), .REFRESH_DIV(4), .SCROLL_DIV(64)) dut4 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
      .wr_ready(wr_ready4), .msg_commit(msg_commit), .scroll_en(scroll_en),
`ifdef SEG14_DIM_EN
      .brightness(brightness),
`endif
      .sel(sel4), .segm(segm4), .frame_tick(frame_tick4)
   );

   function automatic logic [5:0] code_of(input byte ch);
      case (ch)
         "A":     return 6'd0;
         "E":     return 6'd4;
         "S":     return 6'd18;
         "T":     return 6'd19;
         default: return 6'd36;
      endcase
   endfunction

   function automatic logic [13:0] seg_ref(input byte ch);
      case (ch)
         "A":     return 14'b11101111000000;
         "E":     return 14'b10011110000000;
         "S":     return 14'b10110111000000;
         "T":     return 14'b10000000010010;
         default: return 14'b00000000000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int addr, input byte ch, input logic commit);
      wr_en      = 1'b1;
      wr_addr    = addr[3:0];
      wr_char    = code_of(ch);
      msg_commit = commit;
      cycle();
      wr_en      = 1'b0;
      msg_commit = 1'b0;
      shadow_m[addr] = ch;
   endtask

   task automatic wait_copy();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (frame_tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
         chk("rdy_while_pending", wr_ready, 0);
      end
      chk("copy_tick_seen", seen, 1);
      chk("rdy_after_copy", wr_ready, 1);
      active_m = shadow_m;
   endtask

   task automatic check_frame(input int off);
      exp_t e;
      for (int k = 0; k < 12; k++) begin
         e      = '0;
         e.sel  = 12'(1) << k;
         e.segm = seg_ref(active_m[(off + k) % 16]);
         e.tick = (k == 11);
         e.rdy  = 1'b1;
         sb.push_back(e);
      end
      for (int k = 0; k < 12; k++) begin
         cycle();
         e = sb.pop_front();
         chk("frame_sel", sel, e.sel);
         chk("frame_segm", segm, e.segm);
         chk("frame_tick", frame_tick, e.tick);
         chk("frame_rdy", wr_ready, e.rdy);
      end
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; msg_commit = 1'b0; scroll_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         shadow_m[i] = " ";
         active_m[i] = " ";
      end

      // Reset state
      cycle();
      cycle();
      chk("rst_sel", sel, 0);
      chk("rst_segm", segm, 0);
      chk("rst_tick", frame_tick, 0);
      chk("rst_rdy", wr_ready, 1);
      chk("rst_sel4", sel4, 0);
      chk("rst_rdy4", wr_ready4, 1);

      // Blank scan after release, both refresh rates side by side over one slow frame
      rst_n = 1'b1;
      for (int c = 0; c < 48; c++) begin
         e       = '0;
         e.sel   = 12'(1) << (c % 12);
         e.tick  = ((c % 12) == 11);
         e.rdy   = 1'b1;
         e.sel4  = 12'(1) << (c / 4);
         e.tick4 = (c == 47);
         sb.push_back(e);
      end
      for (int c = 0; c < 48; c++) begin
         cycle();
         e = sb.pop_front();
         chk("scan_sel", sel, e.sel);
         chk("scan_segm", segm, e.segm);
         chk("scan_tick", frame_tick, e.tick);
         chk("scan_sel4", sel4, e.sel4);
         chk("scan_tick4", frame_tick4, e.tick4);
         chk("scan_segm4", segm4, 0);
      end

      // Load EASTS; the last write shares its cycle with the commit
      put(0, "E", 1'b0);
      put(1, "A", 1'b0);
      put(2, "S", 1'b0);
      put(3, "T", 1'b0);
      put(4, "S", 1'b1);
      chk("rdy_drop_after_commit", wr_ready, 0);
      wait_copy();
      check_frame(0);

      // Dropped write and repeated commit while a commit is pending
      put(1, "T", 1'b1);
      wr_en = 1'b1; wr_addr = 4'd3; wr_char = code_of("A"); msg_commit = 1'b1;
      cycle();
      wr_en = 1'b0; msg_commit = 1'b0;
      chk("rdy_low_on_drop", wr_ready, 0);
      wait_copy();
      check_frame(0);
      check_frame(0);

      // Scrolling with a two-frame step, through a full offset wrap
      put(0, "A", 1'b0);
      put(1, "E", 1'b1);
      wait_copy();
      scroll_en = 1'b1;
      for (int j = 0; j < 34; j++) begin
         check_frame((j / 2) % 16);
      end
      scroll_en = 1'b0;

      // Reset pulse while a commit is pending
      put(0, "T", 1'b1);
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("midrst_sel", sel, 0);
      chk("midrst_segm", segm, 0);
      chk("midrst_tick", frame_tick, 0);
      chk("midrst_rdy", wr_ready, 1);
      for (int i = 0; i < 16; i++) begin
         shadow_m[i] = " ";
         active_m[i] = " ";
      end
      check_frame(0);
      check_frame(0);
      msg_commit = 1'b1;
      cycle();
      msg_commit = 1'b0;
      wait_copy();
      check_frame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
